// File: rtl/gemm_pkg.sv
// Shared GEMM register map, dim-field layout and sequencer state encoding.
package gemm_pkg;
    localparam logic [31:0] GEMM_A_ADDR   = 32'd0;
    localparam logic [31:0] GEMM_B_ADDR   = 32'd4;
    localparam logic [31:0] GEMM_C_ADDR   = 32'd8;
    localparam logic [31:0] GEMM_A_STRIDE = 32'd12;
    localparam logic [31:0] GEMM_B_STRIDE = 32'd16;
    localparam logic [31:0] GEMM_CTRL     = 32'd20;
    localparam logic [31:0] GEMM_DIM      = 32'd24;

    localparam int DIM_FW     = 5;
    localparam int DIM_M_SH   = 0;
    localparam int DIM_K_SH   = 5;
    localparam int DIM_N_SH   = 10;

    typedef enum logic [3:0] {
        S_IDLE, S_CALC, S_WR_STRA, S_WR_STRB, S_WR_A, S_WR_B, S_WR_C,
        S_WR_CTRL, S_WR_DIM, S_POLL_FULL, S_ADV, S_POLL_DONE, S_FINISH
    } state_t;

    function automatic logic [31:0] pack_dim(input logic [DIM_FW-1:0] ms,
                                             input logic [DIM_FW-1:0] ks,
                                             input logic [DIM_FW-1:0] ns);
        return (32'(ms) << DIM_M_SH) | (32'(ks) << DIM_K_SH) | (32'(ns) << DIM_N_SH);
    endfunction
endpackage

// File: rtl/tile_addr_gen.sv
// Registered tile geometry: edge-clipped sizes, first/last flags and A/B/C tile addresses.
module tile_addr_gen
    import gemm_pkg::*;
#(
    parameter int BLK_M = 16,
    parameter int BLK_K = 16,
    parameter int BLK_N = 16,
    parameter int DIM_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIM_W-1:0]  i_m,
    input  logic [DIM_W-1:0]  i_k,
    input  logic [DIM_W-1:0]  i_n,
    input  logic [DIM_W-1:0]  i_dm,
    input  logic [DIM_W-1:0]  i_dk,
    input  logic [DIM_W-1:0]  i_dn,
    input  logic [31:0]       i_a_base,
    input  logic [31:0]       i_b_base,
    input  logic [31:0]       i_c_base,
    output logic [31:0]       o_a_addr,
    output logic [31:0]       o_b_addr,
    output logic [31:0]       o_c_addr,
    output logic [DIM_FW-1:0] o_msize,
    output logic [DIM_FW-1:0] o_ksize,
    output logic [DIM_FW-1:0] o_nsize,
    output logic              o_first,
    output logic              o_last
);
    logic [31:0] w_m, w_k, w_n, w_dm, w_dk, w_dn;
    logic [DIM_FW-1:0] w_msize, w_ksize, w_nsize;

    assign w_m  = 32'(i_m);
    assign w_k  = 32'(i_k);
    assign w_n  = 32'(i_n);
    assign w_dm = 32'(i_dm);
    assign w_dk = 32'(i_dk);
    assign w_dn = 32'(i_dn);

    // Edge tiles shrink to the remainder of the dimension.
    assign w_msize = (w_m + 32'(BLK_M) > w_dm) ? DIM_FW'(w_dm - w_m) : DIM_FW'(BLK_M);
    assign w_ksize = (w_k + 32'(BLK_K) > w_dk) ? DIM_FW'(w_dk - w_k) : DIM_FW'(BLK_K);
    assign w_nsize = (w_n + 32'(BLK_N) > w_dn) ? DIM_FW'(w_dn - w_n) : DIM_FW'(BLK_N);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_a_addr <= '0;
            o_b_addr <= '0;
            o_c_addr <= '0;
            o_msize  <= '0;
            o_ksize  <= '0;
            o_nsize  <= '0;
            o_first  <= 1'b0;
            o_last   <= 1'b0;
        end else begin
            o_a_addr <= i_a_base + w_k + w_m * w_dk;
            // B is addressed at the last row of the k slab.
            o_b_addr <= i_b_base + w_n + w_k * w_dn + (32'(w_ksize) - 32'd1) * w_dn;
            o_c_addr <= i_c_base + w_n + w_m * w_dn;
            o_msize  <= w_msize;
            o_ksize  <= w_ksize;
            o_nsize  <= w_nsize;
            o_first  <= (w_k == 32'd0);
            o_last   <= (w_k + 32'(BLK_K) >= w_dk);
        end
    end
endmodule

// File: rtl/gemm_tile_sequencer.sv
// Walks the n/m/k tile nest and programs each tile into the GEMM register block over the system bus.
module gemm_tile_sequencer
    import gemm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
    parameter int          BLK_M     = 16,
    parameter int          BLK_K     = 16,
    parameter int          BLK_N     = 16,
    parameter int          DIM_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_m,
    input  logic [DIM_W-1:0] cfg_k,
    input  logic [DIM_W-1:0] cfg_n,
    input  logic [31:0]      cfg_a_base,
    input  logic [31:0]      cfg_b_base,
    input  logic [31:0]      cfg_c_base,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             system_bus_en,
    output logic             system_bus_rdwr,
    output logic [31:0]      system_bus_addr,
    output logic [31:0]      system_bus_wr_data,
    input  logic [31:0]      system_bus_rd_data
);
    state_t            r_state;
    logic [DIM_W-1:0]  r_m, r_k, r_n, r_dm, r_dk, r_dn;
    logic [31:0]       r_a_base, r_b_base, r_c_base;
    logic              r_last_col;

    logic [31:0]       w_a_addr, w_b_addr, w_c_addr;
    logic [DIM_FW-1:0] w_msize, w_ksize, w_nsize;
    logic              w_first, w_last;
    logic [31:0]       w_k_nxt, w_m_nxt, w_n_nxt;
    logic              w_k_end, w_m_end, w_n_end, w_zero, w_unused_rd;

    assign w_zero  = (cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0);
    assign w_k_nxt = 32'(r_k) + 32'(BLK_K);
    assign w_m_nxt = 32'(r_m) + 32'(BLK_M);
    assign w_n_nxt = 32'(r_n) + 32'(BLK_N);
    assign w_k_end = w_k_nxt >= 32'(r_dk);
    assign w_m_end = w_m_nxt >= 32'(r_dm);
    assign w_n_end = w_n_nxt >= 32'(r_dn);
    assign w_unused_rd = ^system_bus_rd_data[31:1];

    tile_addr_gen #(.BLK_M(BLK_M), .BLK_K(BLK_K), .BLK_N(BLK_N), .DIM_W(DIM_W)) u_tag (
        .clk(clk), .rst(rst),
        .i_m(r_m), .i_k(r_k), .i_n(r_n), .i_dm(r_dm), .i_dk(r_dk), .i_dn(r_dn),
        .i_a_base(r_a_base), .i_b_base(r_b_base), .i_c_base(r_c_base),
        .o_a_addr(w_a_addr), .o_b_addr(w_b_addr), .o_c_addr(w_c_addr),
        .o_msize(w_msize), .o_ksize(w_ksize), .o_nsize(w_nsize),
        .o_first(w_first), .o_last(w_last)
    );

    // Bus outputs are loaded on the edge entering a state, so they describe the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_m                <= '0;
            r_k                <= '0;
            r_n                <= '0;
            r_dm               <= '0;
            r_dk               <= '0;
            r_dn               <= '0;
            r_a_base           <= '0;
            r_b_base           <= '0;
            r_c_base           <= '0;
            r_last_col         <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
            system_bus_en      <= 1'b0;
            system_bus_rdwr    <= 1'b0;
            system_bus_addr    <= '0;
            system_bus_wr_data <= '0;
        end else begin
            done            <= 1'b0;
            err             <= 1'b0;
            system_bus_en   <= 1'b0;
            system_bus_rdwr <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_m        <= '0;
                    r_k        <= '0;
                    r_n        <= '0;
                    r_dm       <= cfg_m;
                    r_dk       <= cfg_k;
                    r_dn       <= cfg_n;
                    r_a_base   <= cfg_a_base;
                    r_b_base   <= cfg_b_base;
                    r_c_base   <= cfg_c_base;
                    r_last_col <= 1'b0;
                    if (w_zero) begin
                        r_state <= S_FINISH;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        r_state <= S_CALC;
                        busy    <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_state <= S_WR_STRA;
                    system_bus_en <= 1'b1; system_bus_rdwr <= 1'b1;
                    system_bus_addr <= BASE_ADDR + GEMM_A_STRIDE; system_bus_wr_data <= 32'(r_dk);
                end
                S_WR_STRA: begin
                    r_state <= S_WR_STRB;
                    system_bus_en <= 1'b1; system_bus_rdwr <= 1'b1;
                    system_bus_addr <= BASE_ADDR + GEMM_B_STRIDE; system_bus_wr_data <= 32'(r_dn);
                end
                S_WR_STRB: begin
                    r_state <= S_WR_A;
                    system_bus_en <= 1'b1; system_bus_rdwr <= 1'b1;
                    system_bus_addr <= BASE_ADDR + GEMM_A_ADDR; system_bus_wr_data <= w_a_addr;
                end
                S_WR_A: begin
                    r_state <= S_WR_B;
                    system_bus_en <= 1'b1; system_bus_rdwr <= 1'b1;
                    system_bus_addr <= BASE_ADDR + GEMM_B_ADDR; system_bus_wr_data <= w_b_addr;
                end
                S_WR_B: begin
                    r_state <= S_WR_C;
                    system_bus_en <= 1'b1; system_bus_rdwr <= 1'b1;
                    system_bus_addr <= BASE_ADDR + GEMM_C_ADDR; system_bus_wr_data <= w_c_addr;
                end
                S_WR_C: begin
                    r_state <= S_WR_CTRL;
                    system_bus_en <= 1'b1; system_bus_rdwr <= 1'b1;
                    system_bus_addr <= BASE_ADDR + GEMM_CTRL; system_bus_wr_data <= {30'd0, w_first, w_last};
                end
                S_WR_CTRL: begin
                    r_state <= S_WR_DIM;
                    system_bus_en <= 1'b1; system_bus_rdwr <= 1'b1;
                    system_bus_addr <= BASE_ADDR + GEMM_DIM;
                    system_bus_wr_data <= pack_dim(w_msize, w_ksize, w_nsize);
                end
                S_WR_DIM: begin
                    r_state <= S_POLL_FULL;
                    system_bus_en <= 1'b1;
                    system_bus_addr <= BASE_ADDR + GEMM_A_ADDR;
                end
                S_POLL_FULL: begin
                    if (system_bus_rd_data[0]) begin
                        system_bus_en <= 1'b1;
                        system_bus_addr <= BASE_ADDR + GEMM_A_ADDR;
                    end else begin
                        r_state <= S_ADV;
                    end
                end
                S_ADV: begin
                    if (!w_k_end) begin
                        r_k     <= DIM_W'(w_k_nxt);
                        r_state <= S_CALC;
                    end else if (!w_m_end) begin
                        r_k     <= '0;
                        r_m     <= DIM_W'(w_m_nxt);
                        r_state <= S_CALC;
                    end else begin
                        // Column complete: drain the GEMM before starting the next n column.
                        r_k        <= '0;
                        r_m        <= '0;
                        r_n        <= DIM_W'(w_n_nxt);
                        r_last_col <= w_n_end;
                        r_state    <= S_POLL_DONE;
                        system_bus_en <= 1'b1;
                        system_bus_addr <= BASE_ADDR + GEMM_DIM;
                    end
                end
                S_POLL_DONE: begin
                    if (!system_bus_rd_data[0]) begin
                        system_bus_en <= 1'b1;
                        system_bus_addr <= BASE_ADDR + GEMM_DIM;
                    end else if (r_last_col) begin
                        r_state <= S_FINISH;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_state <= S_CALC;
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end
endmodule
